// File: rtl/joy_dir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : joy_dir_filter
//  Purpose  : N-player joystick direction/fire conditioner. Each player gets
//             a 2-flop synchroniser, a ce-ticked debouncer, SOCD cleanup and
//             a mode-selected restrictor (raw / 4-way last-pressed /
//             4-way first-held / 8-way).
//  Options  : JOY_AUTOFIRE_EN - per-player autofire on the fire output.
//  Revision : 1.0 - initial release
// ============================================================================
module joy_dir_filter #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int AF_HALF_PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [1:0]               mode,
  input  logic [4*NUM_PLAYERS-1:0] dir_in,
  input  logic [NUM_PLAYERS-1:0]   fire_in,
  input  logic [NUM_PLAYERS-1:0]   af_en,
  output logic [4*NUM_PLAYERS-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   fire_out
);

  localparam logic [1:0] C_MODE_RAW   = 2'b00;
  localparam logic [1:0] C_MODE_LAST  = 2'b01;
  localparam logic [1:0] C_MODE_FIRST = 2'b10;
  localparam logic [1:0] C_MODE_WAY8  = 2'b11;

  // Debounce counter only ever holds 0..DEBOUNCE_TICKS-1.
  localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] C_DEB_LAST =
      CNT_W'((DEBOUNCE_TICKS > 0) ? DEBOUNCE_TICKS - 1 : 0);

`ifdef JOY_AUTOFIRE_EN
  localparam int AF_CNT_W = (AF_HALF_PERIOD < 2) ? 1 : $clog2(AF_HALF_PERIOD);
  localparam logic [AF_CNT_W-1:0] C_AF_LAST = AF_CNT_W'(AF_HALF_PERIOD - 1);
`else
  logic unused_af;
  assign unused_af = &{1'b0, af_en, AF_HALF_PERIOD[0]};
`endif

  // Up has the highest priority, right the lowest.
  function automatic logic [3:0] prio1h(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[3])      r = 4'b1000;
    else if (v[2]) r = 4'b0100;
    else if (v[1]) r = 4'b0010;
    else if (v[0]) r = 4'b0001;
    return r;
  endfunction

  logic [1:0] mode_q, mode_d;
  logic       mode_chg;

  // Previous mode, used to detect a mode switch shared by all players.
  always_comb begin
    mode_d   = mode;
    mode_chg = (mode != mode_q);
  end

  // Mode history register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= C_MODE_RAW;
    else       mode_q <= mode_d;
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [4:0]            raw;
    logic [4:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0]            stable_q, stable_d;
    logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            held, rising;
    logic [3:0]            held_prev_q, held_prev_d;
    logic [3:0]            mask_q, mask_d;
    logic [3:0]            dir_q, dir_d;
    logic                  fire_q, fire_d;

    assign raw = {fire_in[p], dir_in[4*p +: 4]};

    // Synchroniser shift and per-bit debounce toward the synced value.
    always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int b = 0; b < 5; b++) begin
        if (DEBOUNCE_TICKS == 0) begin
          stable_d[b] = sync2_q[b];
        end else if (sync2_q[b] == stable_q[b]) begin
          cnt_d[b] = '0;
        end else if (ce) begin
          if (cnt_q[b] == C_DEB_LAST) begin
            stable_d[b] = sync2_q[b];
            cnt_d[b]    = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_W'(1);
          end
        end
      end
    end

    // SOCD cleanup, restrictor mask selection and direction output.
    always_comb begin
      held = stable_q[3:0];
      if (held[3] && held[2]) held[3:2] = 2'b00;
      if (held[1] && held[0]) held[1:0] = 2'b00;
      rising      = held & ~held_prev_q;
      held_prev_d = held;
      mask_d      = '0;
      dir_d       = '0;
      if (!mode_chg) begin
        case (mode)
          C_MODE_RAW:  dir_d = stable_q[3:0];
          C_MODE_WAY8: dir_d = held;
          C_MODE_LAST, C_MODE_FIRST: begin
            mask_d = mask_q;
            if (mode == C_MODE_LAST && rising != 4'b0000)
              mask_d = prio1h(rising);
            else if ((held & mask_q) == 4'b0000)
              mask_d = prio1h(held);
            dir_d = held & mask_d;
          end
          default: dir_d = '0;
        endcase
      end
    end

`ifdef JOY_AUTOFIRE_EN
    logic [AF_CNT_W-1:0] af_cnt_q, af_cnt_d;
    logic                af_phase_q, af_phase_d;

    // Autofire: output high for the first half-period of a hold, then toggles.
    always_comb begin
      af_cnt_d   = af_cnt_q;
      af_phase_d = af_phase_q;
      fire_d     = stable_q[4];
      if (af_en[p] && stable_q[4]) begin
        fire_d = ~af_phase_q;
        if (ce) begin
          if (af_cnt_q == C_AF_LAST) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
          end else begin
            af_cnt_d = af_cnt_q + AF_CNT_W'(1);
          end
        end
      end else begin
        af_cnt_d   = '0;
        af_phase_d = 1'b0;
      end
    end

    // Autofire counter and phase registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        af_cnt_q   <= '0;
        af_phase_q <= 1'b0;
      end else begin
        af_cnt_q   <= af_cnt_d;
        af_phase_q <= af_phase_d;
      end
    end
`else
    // Fire follows the debounced button.
    always_comb begin
      fire_d = stable_q[4];
    end
`endif

    // Per-player pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q     <= '0;
        sync2_q     <= '0;
        stable_q    <= '0;
        cnt_q       <= '0;
        held_prev_q <= '0;
        mask_q      <= '0;
        dir_q       <= '0;
        fire_q      <= 1'b0;
      end else begin
        sync1_q     <= sync1_d;
        sync2_q     <= sync2_d;
        stable_q    <= stable_d;
        cnt_q       <= cnt_d;
        held_prev_q <= held_prev_d;
        mask_q      <= mask_d;
        dir_q       <= dir_d;
        fire_q      <= fire_d;
      end
    end

    assign dir_out[4*p +: 4] = dir_q;
    assign fire_out[p]       = fire_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_joy_dir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joy_dir_filter
//  Purpose  : Scoreboard bench for joy_dir_filter; two instances (no debounce
//             and 3-tick debounce) share the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_joy_dir_filter;

  localparam int NP   = 2;
  localparam int DEB1 = 3;
  localparam int AFH  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] dir_in = 8'h00;
  logic [1:0] fire_in = 2'b00;
  logic [1:0] af_en = 2'b00;
  logic [7:0] d0_dir, d3_dir;
  logic [1:0] d0_fire, d3_fire;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(.NUM_PLAYERS(NP), .DEBOUNCE_TICKS(0), .AF_HALF_PERIOD(AFH)) u_dut_d0 (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode), .dir_in(dir_in),
    .fire_in(fire_in), .af_en(af_en), .dir_out(d0_dir), .fire_out(d0_fire));

  joy_dir_filter #(.NUM_PLAYERS(NP), .DEBOUNCE_TICKS(DEB1), .AF_HALF_PERIOD(AFH)) u_dut_d3 (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode), .dir_in(dir_in),
    .fire_in(fire_in), .af_en(af_en), .dir_out(d3_dir), .fire_out(d3_fire));

  typedef struct packed {
    logic [1:0][7:0] dir;
    logic [1:0][1:0] fire;
  } exp_t;

  exp_t sb[$];

  // Reference model state, indexed [instance][player].
  logic [4:0] m_s1[2][2], m_s2[2][2], m_st[2][2];
  int         m_cnt[2][2][5];
  int         m_sel[2][2];
  logic [3:0] m_hprev[2][2];
  int         m_af[2][2];
  logic [1:0] m_mode_prev[2];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] socd(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (v[3] && v[2]) r[3:2] = 2'b00;
    if (v[1] && v[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  // Index of the highest-priority (highest-numbered) set bit, -1 if none.
  function automatic int top(input logic [3:0] v);
    for (int b = 3; b >= 0; b--) if (v[b]) return b;
    return -1;
  endfunction

  function automatic int deb_of(input int i);
    return (i == 0) ? 0 : DEB1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode_prev[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin
        m_s1[i][p] = '0; m_s2[i][p] = '0; m_st[i][p] = '0;
        m_sel[i][p] = -1; m_hprev[i][p] = '0; m_af[i][p] = 0;
        for (int b = 0; b < 5; b++) m_cnt[i][p][b] = 0;
      end
    end
  endtask

  // Advance the model across the coming rising edge and queue the outputs
  // the DUTs must show after it.
  task automatic model_step();
    exp_t e;
    e = '0;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          logic [3:0] held, rise, od;
          logic       chg, f;
          chg  = (mode != m_mode_prev[i]);
          held = socd(m_st[i][p][3:0]);
          rise = held & ~m_hprev[i][p];
          if (chg || mode == 2'b00 || mode == 2'b11)
            m_sel[i][p] = -1;
          else if (mode == 2'b01 && rise != 4'b0000)
            m_sel[i][p] = top(rise);
          else if (m_sel[i][p] < 0 || !held[m_sel[i][p]])
            m_sel[i][p] = top(held);
          if (chg)                od = 4'b0000;
          else if (mode == 2'b00) od = m_st[i][p][3:0];
          else if (mode == 2'b11) od = held;
          else if (m_sel[i][p] >= 0) od = 4'(1 << m_sel[i][p]);
          else                    od = 4'b0000;
`ifdef JOY_AUTOFIRE_EN
          if (af_en[p] && m_st[i][p][4]) begin
            f = ((m_af[i][p] / AFH) % 2) == 0;
            if (ce) m_af[i][p]++;
          end else begin
            f = m_st[i][p][4];
            m_af[i][p] = 0;
          end
`else
          f = m_st[i][p][4];
`endif
          e.dir[i][4*p +: 4] = od;
          e.fire[i][p]       = f;
          for (int b = 0; b < 5; b++) begin
            if (deb_of(i) == 0) begin
              m_st[i][p][b] = m_s2[i][p][b];
            end else if (m_s2[i][p][b] == m_st[i][p][b]) begin
              m_cnt[i][p][b] = 0;
            end else if (ce) begin
              if (m_cnt[i][p][b] + 1 >= deb_of(i)) begin
                m_st[i][p][b]  = m_s2[i][p][b];
                m_cnt[i][p][b] = 0;
              end else begin
                m_cnt[i][p][b]++;
              end
            end
          end
          m_s2[i][p]    = m_s1[i][p];
          m_s1[i][p]    = {fire_in[p], dir_in[4*p +: 4]};
          m_hprev[i][p] = held;
        end
        m_mode_prev[i] = mode;
      end
    end
    sb.push_back(e);
  endtask

  // One clock of stimulus, applied on the falling edge.
  task automatic cyc(input logic [7:0] d, input logic [1:0] f, input logic [1:0] af,
                     input logic [1:0] md, input logic cen, input logic rs);
    @(negedge clk);
    dir_in  = d;
    fire_in = f;
    af_en   = af;
    mode    = md;
    ce      = cen;
    reset   = rs;
    model_step();
  endtask

  task automatic hold(input logic [7:0] d, input logic [1:0] md, input int n);
    for (int k = 0; k < n; k++) cyc(d, 2'b00, 2'b00, md, 1'b1, 1'b0);
  endtask

  // Monitor: every output cycle pops one expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_dir_deb0",  d0_dir, e.dir[0]);
        chk("sb_fire_deb0", {6'b0, d0_fire}, {6'b0, e.fire[0]});
        chk("sb_dir_deb3",  d3_dir, e.dir[1]);
        chk("sb_fire_deb3", {6'b0, d3_fire}, {6'b0, e.fire[1]});
      end
    end
  end

  initial begin
    logic [7:0] rd;
    logic [1:0] rf, raf, rm;
    logic       rce, rrst;
    model_reset();
    #1;
    chk("reset_dir_deb0", d0_dir, 8'h00);
    chk("reset_dir_deb3", d3_dir, 8'h00);
    chk("reset_fire", {4'b0, d0_fire, d3_fire}, 8'h00);
    for (int k = 0; k < 3; k++) cyc(8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);

    // Reset while up is held: zero during reset, up four clocks after release.
    hold(8'h08, 2'b00, 6);
    cyc(8'h08, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    #1;
    chk("midreset_dir_deb0", d0_dir, 8'h00);
    chk("midreset_dir_deb3", d3_dir, 8'h00);
    cyc(8'h08, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    cyc(8'h08, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    hold(8'h08, 2'b00, 3);
    chk("release_3clk", {4'b0, d0_dir[3:0]}, 8'h00);
    hold(8'h08, 2'b00, 1);
    chk("release_4clk", {4'b0, d0_dir[3:0]}, 8'h08);

    // Debounce: a 2-tick glitch on right is rejected, a steady press accepted.
    hold(8'h00, 2'b11, 10);
    hold(8'h01, 2'b11, 2);
    hold(8'h00, 2'b11, 8);
    chk("glitch_rejected", {4'b0, d3_dir[3:0]}, 8'h00);
    hold(8'h01, 2'b11, 10);
    chk("press_accepted", {4'b0, d3_dir[3:0]}, 8'h01);

    // 4-way last-pressed.
    hold(8'h02, 2'b01, 10);
    chk("last_left", {d3_dir[3:0], d0_dir[3:0]}, 8'h22);
    hold(8'h0A, 2'b01, 10);
    chk("last_add_up", {d3_dir[3:0], d0_dir[3:0]}, 8'h88);
    hold(8'h02, 2'b01, 10);
    chk("last_rel_up", {d3_dir[3:0], d0_dir[3:0]}, 8'h22);
    hold(8'h0E, 2'b01, 10);
    chk("last_socd", {d3_dir[3:0], d0_dir[3:0]}, 8'h22);

    // 4-way first-held.
    hold(8'h02, 2'b10, 10);
    hold(8'h0A, 2'b10, 10);
    chk("first_add_up", {d3_dir[3:0], d0_dir[3:0]}, 8'h22);
    hold(8'h08, 2'b10, 10);
    chk("first_rel_left", {d3_dir[3:0], d0_dir[3:0]}, 8'h88);

    // Raw vs 8-way, then one zero clock on a mode switch.
    hold(8'h0A, 2'b00, 10);
    chk("raw_diag", {4'b0, d0_dir[3:0]}, 8'h0A);
    hold(8'h0A, 2'b11, 10);
    chk("way8_diag", {4'b0, d0_dir[3:0]}, 8'h0A);
    hold(8'h0C, 2'b00, 10);
    chk("raw_opposite", {4'b0, d0_dir[3:0]}, 8'h0C);
    hold(8'h0C, 2'b11, 10);
    chk("way8_opposite", {4'b0, d0_dir[3:0]}, 8'h00);
    hold(8'h0A, 2'b11, 10);
    hold(8'h0A, 2'b01, 1);
    hold(8'h0A, 2'b01, 1);
    chk("modechg_zero", {4'b0, d0_dir[3:0]}, 8'h00);
    hold(8'h0A, 2'b01, 1);
    chk("modechg_reselect", {4'b0, d0_dir[3:0]}, 8'h08);

    // Fire held with autofire enabled, ce every clock.
    for (int k = 0; k < 6; k++) cyc(8'h00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      logic exp_f;
      cyc(8'h00, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
`ifdef JOY_AUTOFIRE_EN
      exp_f = (k >= 5 && k <= 8) || (k >= 13);
`else
      exp_f = (k >= 5);
`endif
      if (k >= 5) chk("autofire_seq", {7'b0, d0_fire[0]}, {7'b0, exp_f});
    end
    for (int k = 0; k < 5; k++) cyc(8'h00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
    chk("fire_release", {7'b0, d0_fire[0]}, 8'h00);

    // Randomised traffic, slowly changing so the debounced instance sees presses.
    rd = 8'h00; rf = 2'b00; raf = 2'b00; rm = 2'b01;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) rd[b] = ~rd[b];
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 11) == 0) rf[b] = ~rf[b];
      if ($urandom_range(0, 99) == 0) raf = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) rm = 2'($urandom_range(0, 3));
      rce  = ($urandom_range(0, 2) != 0);
      rrst = ($urandom_range(0, 399) == 0);
      cyc(rd, rf, raf, rm, rce, rrst);
    end

    hold(8'h00, 2'b00, 4);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
